// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the core step controller: state encoding and default widths.
package cpu_ctrl_pkg;

   localparam int unsigned DEF_PC_W       = 8;
   localparam int unsigned DEF_CNT_W      = 16;
   localparam int unsigned DEF_RST_CYCLES = 16;

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_RUN   = 2'd2,
      ST_BREAK = 2'd3
   } state_e;

endpackage : cpu_ctrl_pkg

// File: rtl/edge_detect.sv
// Registered rising-edge detector: a level first sampled high yields a one-cycle
// o_rise during the following cycle.
module edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic i_level,
   output logic o_rise
);

   logic prev_q;
   logic rise_q;
   logic rise_d;

   always_comb begin
      rise_d = i_level & ~prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         prev_q <= i_level;
         rise_q <= rise_d;
      end
   end

   assign o_rise = rise_q;

endmodule : edge_detect

// File: rtl/cpu_step_controller.sv
// Core sequencer: turns debounced front-panel controls into a one-cycle core clock
// enable and a held core reset, with single-step, free-run and breakpoint halt.
module cpu_step_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned PC_W       = DEF_PC_W,
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned RST_CYCLES = DEF_RST_CYCLES
) (
   input  logic             i_CLK,
   input  logic             i_RST_n,
   input  logic             i_Step,
   input  logic             i_Run,
   input  logic             i_PCReset,
   input  logic [CNT_W-1:0] i_Period,
   input  logic             i_BreakEn,
   input  logic [PC_W-1:0]  i_BreakPC,
   input  logic [PC_W-1:0]  i_PC,
   output logic             o_CPU_CE,
   output logic             o_CPU_RST,
   output logic             o_Running,
   output logic             o_Halted,
   output logic [CNT_W-1:0] o_InstrCount
);

   localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_CYCLES - 1);

   state_e             state_q,   state_d;
   logic [HOLD_W-1:0]  hold_q,    hold_d;
   logic [CNT_W-1:0]   period_q,  period_d;
   logic [CNT_W-1:0]   count_q,   count_d;
   logic               skip_q,    skip_d;
   logic               ce_q,      ce_d;
   logic               rst_q,     rst_d;
   logic               running_q, running_d;
   logic               halted_q,  halted_d;

   logic step_rise;
   logic run_rise;
   logic pcr_rise;
   logic break_hit_c;

   edge_detect u_step_edge (.clk(i_CLK), .rst_n(i_RST_n), .i_level(i_Step),    .o_rise(step_rise));
   edge_detect u_run_edge  (.clk(i_CLK), .rst_n(i_RST_n), .i_level(i_Run),     .o_rise(run_rise));
   edge_detect u_pcr_edge  (.clk(i_CLK), .rst_n(i_RST_n), .i_level(i_PCReset), .o_rise(pcr_rise));

   // skip lets the first run pulse execute the instruction sitting on the breakpoint
   assign break_hit_c = i_BreakEn && (i_PC == i_BreakPC) && !skip_q;

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      period_d = period_q;
      skip_d   = skip_q;
      ce_d     = 1'b0;

      if (pcr_rise) begin
         state_d = ST_HOLD;
         hold_d  = HOLD_INIT;
         skip_d  = 1'b0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               if (hold_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  hold_d = hold_q - HOLD_W'(1);
               end
            end
            ST_IDLE: begin
               if (run_rise) begin
                  state_d  = ST_RUN;
                  period_d = i_Period;
                  skip_d   = 1'b1;
               end else if (step_rise) begin
                  ce_d = 1'b1;
               end
            end
            ST_RUN: begin
               if (run_rise) begin
                  state_d = ST_IDLE;
               end else if (period_q == '0) begin
                  period_d = i_Period;
                  if (break_hit_c) begin
                     state_d = ST_BREAK;
                  end else begin
                     ce_d   = 1'b1;
                     skip_d = 1'b0;
                  end
               end else begin
                  period_d = period_q - CNT_W'(1);
               end
            end
            ST_BREAK: begin
               if (run_rise) begin
                  state_d  = ST_RUN;
                  period_d = i_Period;
                  skip_d   = 1'b1;
               end else if (step_rise) begin
                  ce_d    = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_HOLD;
               hold_d  = HOLD_INIT;
            end
         endcase
      end

      rst_d     = (state_d == ST_HOLD);
      running_d = (state_d == ST_RUN);
      halted_d  = (state_d == ST_BREAK);

      if (state_d == ST_HOLD) begin
         count_d = '0;
      end else if (ce_d) begin
         count_d = count_q + CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge i_CLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         state_q   <= ST_HOLD;
         hold_q    <= HOLD_INIT;
         period_q  <= '0;
         count_q   <= '0;
         skip_q    <= 1'b0;
         ce_q      <= 1'b0;
         rst_q     <= 1'b1;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         period_q  <= period_d;
         count_q   <= count_d;
         skip_q    <= skip_d;
         ce_q      <= ce_d;
         rst_q     <= rst_d;
         running_q <= running_d;
         halted_q  <= halted_d;
      end
   end

   assign o_CPU_CE     = ce_q;
   assign o_CPU_RST    = rst_q;
   assign o_Running    = running_q;
   assign o_Halted     = halted_q;
   assign o_InstrCount = count_q;

endmodule : cpu_step_controller

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller; every CE pulse is matched against a queue
// of expected instruction counts, and i_PC models a core advancing once per pulse.
module tb_cpu_step_controller;

   localparam int unsigned PC_W       = 8;
   localparam int unsigned CNT_W      = 16;
   localparam int unsigned RST_CYCLES = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             i_Step;
   logic             i_Run;
   logic             i_PCReset;
   logic [CNT_W-1:0] i_Period;
   logic             i_BreakEn;
   logic [PC_W-1:0]  i_BreakPC;
   logic [PC_W-1:0]  i_PC;
   logic             o_CPU_CE;
   logic             o_CPU_RST;
   logic             o_Running;
   logic             o_Halted;
   logic [CNT_W-1:0] o_InstrCount;

   int total   = 0;
   int bad     = 0;
   int ce_seen = 0;
   int ce_base = 0;
   int exp_cnt = 0;
   logic [CNT_W-1:0] sb[$];

   always #5 clk = ~clk;

   assign i_PC = PC_W'(ce_seen - ce_base);

   cpu_step_controller #(
      .PC_W       (PC_W),
      .CNT_W      (CNT_W),
      .RST_CYCLES (RST_CYCLES)
   ) dut (
      .i_CLK        (clk),
      .i_RST_n      (rst_n),
      .i_Step       (i_Step),
      .i_Run        (i_Run),
      .i_PCReset    (i_PCReset),
      .i_Period     (i_Period),
      .i_BreakEn    (i_BreakEn),
      .i_BreakPC    (i_BreakPC),
      .i_PC         (i_PC),
      .o_CPU_CE     (o_CPU_CE),
      .o_CPU_RST    (o_CPU_RST),
      .o_Running    (o_Running),
      .o_Halted     (o_Halted),
      .o_InstrCount (o_InstrCount)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         exp_cnt++;
         sb.push_back(CNT_W'(exp_cnt));
      end
   endtask

   // advance to the next falling edge(s), retiring any CE pulse against the scoreboard
   task automatic tick(input int n);
      logic [CNT_W-1:0] e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (rst_n && o_CPU_CE) begin
            ce_seen++;
            chk("ce_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("instr_count_at_ce", 32'(o_InstrCount), 32'(e));
            end
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      i_Step    = 1'b0;
      i_Run     = 1'b0;
      i_PCReset = 1'b0;
      i_Period  = '0;
      i_BreakEn = 1'b0;
      i_BreakPC = '0;
      tick(3);
      chk("rst_ce",      32'(o_CPU_CE),     32'd0);
      chk("rst_cpurst",  32'(o_CPU_RST),    32'd1);
      chk("rst_running", 32'(o_Running),    32'd0);
      chk("rst_halted",  32'(o_Halted),     32'd0);
      chk("rst_count",   32'(o_InstrCount), 32'd0);

      // reset release: core reset held for RST_CYCLES cycles
      rst_n = 1'b1;
      for (int c = 0; c <= 16; c++) begin
         chk("hold_cpurst", 32'(o_CPU_RST), 32'(c < 16));
         if (c < 16) tick(1);
      end
      chk("idle_ce",      32'(o_CPU_CE),     32'd0);
      chk("idle_running", 32'(o_Running),    32'd0);
      chk("idle_halted",  32'(o_Halted),     32'd0);
      chk("idle_count",   32'(o_InstrCount), 32'd0);

      // single step, twice
      for (int r = 0; r < 2; r++) begin
         push_pulses(1);
         i_Step = 1'b1;
         for (int c = 1; c <= 10; c++) begin
            tick(1);
            chk("step_ce", 32'(o_CPU_CE), 32'(c == 2));
         end
         i_Step = 1'b0;
         tick(3);
      end
      chk("step_count", 32'(o_InstrCount), 32'd2);
      chk("step_sb_empty", 32'(sb.size()), 32'd0);

      // free run, period 3
      i_Period = CNT_W'(3);
      push_pulses(3);
      i_Run = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         tick(1);
         if (c == 2) i_Run = 1'b0;
         chk("run_ce", 32'(o_CPU_CE), 32'(c == 6 || c == 10 || c == 14));
         if (c >= 2) chk("run_running", 32'(o_Running), 32'd1);
      end
      i_Run = 1'b1;
      tick(1);
      i_Run = 1'b0;
      tick(1);
      chk("stop_running", 32'(o_Running), 32'd0);
      for (int c = 0; c < 8; c++) begin
         tick(1);
         chk("stop_ce", 32'(o_CPU_CE), 32'd0);
      end
      chk("run_count", 32'(o_InstrCount), 32'd5);
      chk("run_sb_empty", 32'(sb.size()), 32'd0);

      // breakpoint at PC 5, period 0
      i_Period  = '0;
      i_BreakEn = 1'b1;
      i_BreakPC = PC_W'(5);
      ce_base   = ce_seen;
      push_pulses(5);
      i_Run = 1'b1;
      tick(1);
      i_Run = 1'b0;
      for (int c = 2; c <= 8; c++) begin
         tick(1);
         chk("bp_ce", 32'(o_CPU_CE), 32'(c >= 3 && c <= 7));
      end
      chk("bp_halted",  32'(o_Halted),     32'd1);
      chk("bp_running", 32'(o_Running),    32'd0);
      chk("bp_count",   32'(o_InstrCount), 32'd10);
      tick(3);
      chk("bp_stay_halted", 32'(o_Halted), 32'd1);

      // resume from the breakpoint: first pulse despite PC == break address
      push_pulses(2);
      i_Run = 1'b1;
      tick(1);
      i_Run = 1'b0;
      tick(1);
      chk("resume_running", 32'(o_Running), 32'd1);
      chk("resume_halted",  32'(o_Halted),  32'd0);
      chk("resume_ce0",     32'(o_CPU_CE),  32'd0);
      tick(1);
      chk("resume_skip_ce", 32'(o_CPU_CE),  32'd1);
      i_Run = 1'b1;
      tick(1);
      chk("resume_ce2", 32'(o_CPU_CE), 32'd1);
      i_Run = 1'b0;
      tick(1);
      chk("resume_stop_running", 32'(o_Running), 32'd0);
      chk("resume_stop_ce",      32'(o_CPU_CE),  32'd0);
      chk("resume_count", 32'(o_InstrCount), 32'd12);

      // hit the breakpoint again, then step off it
      ce_base = ce_seen;
      push_pulses(5);
      i_Run = 1'b1;
      tick(1);
      i_Run = 1'b0;
      tick(7);
      chk("bp2_halted", 32'(o_Halted),     32'd1);
      chk("bp2_count",  32'(o_InstrCount), 32'd17);
      tick(2);
      push_pulses(1);
      i_Step = 1'b1;
      tick(1);
      chk("bstep_ce0",    32'(o_CPU_CE), 32'd0);
      chk("bstep_halt0",  32'(o_Halted), 32'd1);
      tick(1);
      chk("bstep_ce",      32'(o_CPU_CE),  32'd1);
      chk("bstep_halted",  32'(o_Halted),  32'd0);
      chk("bstep_running", 32'(o_Running), 32'd0);
      i_Step = 1'b0;
      tick(3);
      chk("bstep_idle_ce", 32'(o_CPU_CE),     32'd0);
      chk("bstep_count",   32'(o_InstrCount), 32'd18);
      chk("bp_sb_empty",   32'(sb.size()),    32'd0);
      i_BreakEn = 1'b0;

      // PC reset, run and step rising together while running
      i_Period = CNT_W'(100);
      i_Run = 1'b1;
      tick(1);
      i_Run = 1'b0;
      tick(3);
      chk("pri_pre_running", 32'(o_Running), 32'd1);
      i_PCReset = 1'b1;
      i_Run     = 1'b1;
      i_Step    = 1'b1;
      tick(2);
      exp_cnt = 0;
      chk("pri_cpurst",  32'(o_CPU_RST),    32'd1);
      chk("pri_ce",      32'(o_CPU_CE),     32'd0);
      chk("pri_count",   32'(o_InstrCount), 32'd0);
      chk("pri_running", 32'(o_Running),    32'd0);
      i_PCReset = 1'b0;
      i_Run     = 1'b0;
      i_Step    = 1'b0;
      tick(15);
      chk("pri_hold_still", 32'(o_CPU_RST), 32'd1);
      tick(1);
      chk("pri_hold_done",  32'(o_CPU_RST), 32'd0);
      chk("pri_idle_run",   32'(o_Running), 32'd0);

      // run and step rising together in idle: run wins
      i_Run  = 1'b1;
      i_Step = 1'b1;
      tick(2);
      chk("rs_running", 32'(o_Running), 32'd1);
      chk("rs_ce",      32'(o_CPU_CE),  32'd0);
      i_Run  = 1'b0;
      i_Step = 1'b0;
      tick(5);
      chk("rs_count", 32'(o_InstrCount), 32'd0);
      i_Run = 1'b1;
      tick(2);
      i_Run = 1'b0;
      chk("rs_stop_running", 32'(o_Running), 32'd0);
      tick(1);
      chk("rs_sb_empty", 32'(sb.size()), 32'd0);

      // instruction counter wrap: 65535 run pulses, then one step
      i_Period = '0;
      push_pulses(65535);
      i_Run = 1'b1;
      tick(1);
      i_Run = 1'b0;
      tick(65535);
      i_Run = 1'b1;
      tick(1);
      i_Run = 1'b0;
      tick(1);
      chk("wrap_full",    32'(o_InstrCount), 32'h0000_FFFF);
      chk("wrap_running", 32'(o_Running),    32'd0);
      push_pulses(1);
      i_Step = 1'b1;
      tick(2);
      chk("wrap_ce",    32'(o_CPU_CE),     32'd1);
      chk("wrap_count", 32'(o_InstrCount), 32'd0);
      i_Step = 1'b0;
      tick(2);
      chk("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cpu_step_controller
